button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Input-side counterpart to the LED output path: conditions a raw push-button pin into clean, debounced events for top-level logic.
- Runs in the 48 MHz SB_HFOSC clock domain and is reset from the resetter output.
- Provides a level output, single-cycle press/release/long-press pulses and a wrapping press counter.

Parameters:
- DEBOUNCE_CYCLES, 480000, consecutive stable cycles required to accept a level change (10 ms at 48 MHz); must be >= 1.
- LONG_PRESS_CYCLES, 48000000, cycles spent in PRESSED before long_press_pulse fires (1 s); must be >= 1.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; input is inverted before synchronisation.

Ports:
- clock  input  1  system clock (48 MHz).
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  1  asynchronous button pin.
- pressed  output  1  debounced level, 1 = held.
- press_pulse  output  1  one-cycle strobe on each accepted press.
- release_pulse  output  1  one-cycle strobe on each accepted release.
- long_press_pulse  output  1  one-cycle strobe, at most once per press.
- press_count  output  8  number of accepted presses, modulo 256.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state = RELEASED, all counters = 0, sync flops = "not pressed".
  - All outputs = 0.
- Synchroniser: normalise s_in = ACTIVE_LOW ? ~btn_raw : btn_raw, then pass s_in through 2 flops. The second flop output s drives the FSM.
- Counter widths:
  - deb_cnt is $clog2(DEBOUNCE_CYCLES+1) bits.
  - hold_cnt is $clog2(LONG_PRESS_CYCLES+1) bits.
- FSM states and transitions:
  - RELEASED: s=1 -> PRESS_WAIT, deb_cnt=0.
  - PRESS_WAIT, s=0: -> RELEASED. Glitch rejected; no pulse, no count change.
  - PRESS_WAIT, s=1, deb_cnt==DEBOUNCE_CYCLES-1: -> PRESSED. pressed<=1, press_pulse<=1, press_count<=press_count+1, hold_cnt<=0, long_done<=0.
  - PRESS_WAIT, s=1, otherwise: deb_cnt++.
  - PRESSED: hold_cnt increments, saturating at LONG_PRESS_CYCLES-1.
    - On reaching LONG_PRESS_CYCLES-1 with long_done=0: long_press_pulse<=1, long_done<=1.
    - s=0 -> RELEASE_WAIT, deb_cnt=0.
  - RELEASE_WAIT, s=1: -> PRESSED. Release glitch rejected; hold_cnt and long_done are retained, hold_cnt is frozen while in RELEASE_WAIT.
  - RELEASE_WAIT, s=0, deb_cnt==DEBOUNCE_CYCLES-1: -> RELEASED. pressed<=0, release_pulse<=1.
  - RELEASE_WAIT, s=0, otherwise: deb_cnt++.
- Output timing:
  - All outputs are registered.
  - Each pulse is high for exactly 1 cycle.
  - press_pulse and release_pulse never coincide.
- Latency: for a clean step on btn_raw captured at edge 0, pressed and press_pulse go high after edge DEBOUNCE_CYCLES+2. Release is symmetric.
- long_press_pulse fires LONG_PRESS_CYCLES cycles after the PRESSED entry edge, provided no release glitch occurs in between.
- press_count wraps from 255 to 0 with no flag.
- Reset mid-press: all state is cleared immediately. If the button is still held at deassertion, a fresh press is accepted after DEBOUNCE_CYCLES+2 edges, with press_count = 1.

Decomposition:
- Shared package button_pkg holds:
  - FSM state encodings: RELEASED=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3.
  - 48 MHz default constants DEBOUNCE_10MS and LONG_1S.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with asynchronous reset to a parameterised RESET_VAL. It is reusable by the other pin inputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1):
- Reset, then hold btn_raw=1 for 50 cycles -> all outputs 0 throughout, press_count=0.
- Step btn_raw 1->0 at edge 0 and hold -> press_pulse high only after edge 6, pressed=1, press_count=1. Then long_press_pulse high only after edge 26, exactly once, even if held 100 cycles.
- Low glitch of 3 synchronised cycles -> returns to RELEASED; no press_pulse, press_count unchanged.
- While pressed, high glitch of 2 cycles, then low -> pressed stays 1, no release_pulse, no second press_pulse. A clean release held 10 cycles -> a single release_pulse, 6 edges after the step.
- 257 clean press/release cycles -> press_count = 1 after wrap, and 257 press_pulses counted.
- Assert reset for 1 cycle at hold_cnt=10 while held -> outputs cleared asynchronously. After deassertion: press_pulse after 6 edges, press_count=1, long_press_pulse 20 cycles later.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the push-button input path: FSM encodings and
// 48 MHz timing defaults.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int unsigned DEBOUNCE_10MS = 480_000;
  localparam int unsigned LONG_1S       = 48_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous pin inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button pin into a clean level, press/release/long-press
// strobes and a wrapping press counter.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_1S,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic          s_in;
  logic          s;
  state_t        state;
  state_t        state_next;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          long_done;
  logic          deb_last;
  logic          accept_press;
  logic          accept_release;
  logic          fire_long;

  assign s_in = ACTIVE_LOW ? ~btn_raw : btn_raw;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (s_in),
    .q     (s)
  );

  assign deb_last = (deb_cnt == DEB_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RELEASED;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      RELEASED:     if (s) state_next = PRESS_WAIT;
      PRESS_WAIT:   if (!s) state_next = RELEASED;
                    else if (deb_last) state_next = PRESSED;
      PRESSED:      if (!s) state_next = RELEASE_WAIT;
      RELEASE_WAIT: if (s) state_next = PRESSED;
                    else if (deb_last) state_next = RELEASED;
    endcase
  end

  always_comb begin
    accept_press   = (state == PRESS_WAIT) && s && deb_last;
    accept_release = (state == RELEASE_WAIT) && !s && deb_last;
    fire_long      = (state == PRESSED) && (hold_cnt == HOLD_LAST) && !long_done;
  end

  // NOTE: every control flop is reset; there is no memory array here, so
  // nothing is exempt from the asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_cnt          <= '0;
      hold_cnt         <= '0;
      long_done        <= 1'b0;
      pressed          <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= 8'd0;
    end else begin
      press_pulse      <= accept_press;
      release_pulse    <= accept_release;
      long_press_pulse <= fire_long;

      // Debounce window restarts on every state change.
      if (state_next != state)
        deb_cnt <= '0;
      else if (state == PRESS_WAIT || state == RELEASE_WAIT)
        deb_cnt <= deb_cnt + 1'b1;

      if (accept_press) begin
        pressed     <= 1'b1;
        press_count <= press_count + 8'd1;
        hold_cnt    <= '0;
        long_done   <= 1'b0;
      end else if (state == PRESSED) begin
        if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
        if (fire_long) long_done <= 1'b1;
      end

      if (accept_release) pressed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a run-length reference model pushes
// expected strobes, a negedge monitor pops and compares them.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int L = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b1;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic [7:0] press_count;

  button_debouncer #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .btn_raw          (btn_raw),
    .pressed          (pressed),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .press_count      (press_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    bit         p;
    bit         r;
    bit         l;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  n_press_seen = 0;
  int  n_long_seen = 0;

  // Reference model: button level is accepted after D+1 consecutive agreeing
  // synchronised samples; hold time counts samples spent with no release run.
  bit         m_s1, m_s2, m_pressed, m_long_done;
  int         run, hold;
  logic [7:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock or posedge reset) begin : model
    bit  s_now;
    ev_t e;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0; m_long_done = 0;
      run = 0; hold = 0; m_count = 8'd0;
      exp_q.delete();
    end else begin
      cyc++;
      s_now = m_s2;
      m_s2  = m_s1;
      m_s1  = ~btn_raw;
      e.cyc = cyc; e.p = 0; e.r = 0; e.l = 0; e.cnt = 8'd0;
      if (!m_pressed) begin
        run = s_now ? run + 1 : 0;
        if (run == D + 1) begin
          m_pressed = 1; m_count = m_count + 8'd1; e.p = 1;
          run = 0; hold = 0; m_long_done = 0;
        end
      end else begin
        if (run == 0) begin
          if (hold == L - 1 && !m_long_done) begin
            e.l = 1; m_long_done = 1;
          end
          if (hold < L - 1) hold++;
        end
        run = s_now ? 0 : run + 1;
        if (run == D + 1) begin
          m_pressed = 0; e.r = 1; run = 0;
        end
      end
      if (e.p || e.r || e.l) begin
        e.cnt = m_count;
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clock) begin : monitor
    ev_t e;
    #1;
    if (reset) begin
      check("reset_outputs", {pressed, press_pulse, release_pulse, long_press_pulse, press_count}, 0);
    end else begin
      e.cyc = cyc; e.p = 0; e.r = 0; e.l = 0; e.cnt = m_count;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
      if (press_pulse || release_pulse || long_press_pulse || e.p || e.r || e.l) begin
        check("pulses_prl", {press_pulse, release_pulse, long_press_pulse}, {e.p, e.r, e.l});
        check("event_count", press_count, e.cnt);
      end
      if (press_pulse) n_press_seen++;
      if (long_press_pulse) n_long_seen++;
      check("pressed_level", pressed, m_pressed);
      check("press_count", press_count, m_count);
    end
  end

  task automatic hold_btn(input logic v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle released: nothing may happen.
    hold_btn(1'b1, 50);
    check("idle_count", press_count, 0);
    check("idle_presses", n_press_seen, 0);

    // Long hold: one press, one long press.
    hold_btn(1'b0, 100);
    check("hold_count", press_count, 1);
    check("long_once", n_long_seen, 1);
    hold_btn(1'b1, 10);
    check("released", pressed, 0);

    // Press glitches of 3 and D cycles are rejected.
    hold_btn(1'b0, 3);
    hold_btn(1'b1, 10);
    hold_btn(1'b0, D);
    hold_btn(1'b1, 10);
    check("glitch_count", press_count, 1);

    // Release glitch while held, then clean release.
    hold_btn(1'b0, 10);
    hold_btn(1'b1, 2);
    hold_btn(1'b0, 10);
    check("still_pressed", pressed, 1);
    hold_btn(1'b1, 10);
    check("two_presses", n_press_seen, 2);

    // Counter wrap from a fresh reset.
    pulse_reset();
    n_press_seen = 0;
    for (int i = 0; i < 257; i++) begin
      hold_btn(1'b0, D + 1 + $urandom_range(0, 4));
      hold_btn(1'b1, D + 1 + $urandom_range(0, 4));
    end
    hold_btn(1'b1, 10);
    check("wrap_count", press_count, 1);
    check("wrap_presses", n_press_seen, 257);

    // Reset mid-press with the button still held.
    hold_btn(1'b0, 17);
    check("pre_reset_pressed", pressed, 1);
    #2 reset = 1'b1;
    #1;
    check("async_clear_pressed", pressed, 0);
    check("async_clear_count", press_count, 0);
    @(negedge clock);
    reset = 1'b0;
    n_long_seen = 0;
    n_press_seen = 0;
    hold_btn(1'b0, 40);
    check("post_reset_count", press_count, 1);
    check("post_reset_long", n_long_seen, 1);
    hold_btn(1'b1, 10);

    // Random bouncing against the model.
    for (int i = 0; i < 80; i++)
      hold_btn(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    hold_btn(1'b1, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
